hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised forwarding and hazard unit for the Lapido pipeline. It keeps its own shift-register record of in-flight writers, so stages no longer pass `rd` and `regWrite` values into it. It generates per-operand forward selects for the instruction in EX and a load-use stall for the instruction in ID. It also applies flush and external-freeze control and keeps a saturating stall counter. It sits beside the ID/EX pipeline register and drives the EX operand muxes and the PC/IF-ID write enables.

## Interface
- `REG_AW`, default 4: register address width.
- `DEPTH`, default 3: tracked stages after ID. Stage 1 is EX and stage `DEPTH` is WB. Legal range is 2..7.
- `LOAD_STAGE`, default 3: first stage at which load data can be forwarded. Legal range is 2..`DEPTH`.
- `ZERO_REG`, default 1: when 1, register 0 never matches as either source or destination.
- `CNT_W`, default 16: width of the stall counter.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `id_valid` input, 1 bit: the ID slot holds a real instruction.
- `id_regWrite` input, 1 bit: the ID instruction writes `id_registerRD`.
- `id_memRead` input, 1 bit: the ID instruction is a load.
- `id_registerRD`, `id_registerA`, `id_registerB` inputs, `REG_AW` bits each: destination and source addresses.
- `id_useA`, `id_useB` inputs, 1 bit each: the source operand is actually read.
- `flush` input, 1 bit: kill the ID instruction and insert a bubble into stage 1.
- `ext_stall` input, 1 bit: freeze all tracker state (memory wait).
- `stall` output, 1 bit: load-use hazard. Hold PC and IF/ID, and insert a bubble.
- `forwardA`, `forwardB` outputs, `$clog2(DEPTH+1)` bits each: value 0 selects the register file; value k (2..`DEPTH`) selects the result of stage k.
- `stall_count` output, `CNT_W` bits: number of cycles in which `stall` was 1 and `ext_stall` was 0. Saturates at all-ones.

## Operation
- **Tracker state.** Each stage s (1..`DEPTH`) holds `v[s]`, `wr[s]`, `ld[s]` and `rd[s]`. Stage 1 also holds `srcA`/`srcB` and `useA`/`useB`.
- **Match rule.** A source matches stage s when all of these hold:
  - `v[s]` and `wr[s]` are 1;
  - `rd[s]` equals the source address;
  - the source's `use` bit is set;
  - the address is not zero, when `ZERO_REG` is 1.
- **Forwarding.** `forwardA` is the lowest s in 2..`DEPTH` that matches the stage-1 `srcA`, or 0 if none matches; `forwardB` is computed the same way from `srcB`. The youngest producer always wins. These outputs are combinational from registered state only; there is no path from ID inputs.
- **Stall.** Take the ID sources, and for each the youngest matching stage m among 1..`DEPTH`-1. `stall` is 1 when `id_valid` is 1, `ld[m]` is 1 and m+1 < `LOAD_STAGE`. A younger non-load producer of the same register masks an older load.
- **Advance, when `ext_stall` is 0.**
  - Stage s+1 takes the contents of stage s.
  - Stage 1 takes the ID instruction when `id_valid` is 1, `stall` is 0 and `flush` is 0.
  - Otherwise stage 1 takes a bubble (`v`=0).
- **Freeze, when `ext_stall` is 1.** All stages hold their state and the counter holds. `stall` is still computed.
- **Priority:** `ext_stall` over `flush`, and `flush` over `stall`. When `flush` and `stall` are both 1, stage 1 takes a bubble and the counter still increments.
- **Reset.** All `v` bits are cleared. `forwardA`, `forwardB`, `stall` and `stall_count` are all 0. Reset mid-operation discards every in-flight record immediately.

## Timing
- Forward select is valid in the same cycle an instruction occupies stage 1. In effect it is decided one cycle earlier and captured into the tracker.
- The stall decision has combinational latency within the ID cycle. A load with one dependent instruction behind it, at default parameters, gives exactly 1 stall cycle.
- With `LOAD_STAGE`=`DEPTH`=4, a load directly followed by a consumer gives 2 stall cycles.
- The counter updates on the edge following each counted cycle.

## Structure
- Package `hfu_pkg` holds:
  - the `FWD_RF` constant (0);
  - the select-width helper `$clog2(DEPTH+1)`;
  - the stage record typedef (`v`, `wr`, `ld`, `rd`).
- Sub-module `fwd_match` is a priority matcher over a stage range with a parametrised start stage. It returns the matched index and a found flag. It is instantiated four times: A/B forwarding and A/B stall.

## Test plan
- **Back-to-back ALU forwarding.**
  - Issue `add r3` then `sub r5,r3,r3`: `forwardA`=`forwardB`=2 in the sub's EX cycle and `stall`=0.
  - Issue two instructions writing r3 ahead of a reader: the reader gets 2, not 3.
- **Load-use at defaults.** Issue `ld r4` then `add r1,r4,r2`: `stall`=1 for exactly one cycle, then `forwardA`=3, `forwardB`=0 and `stall_count`=1.
- **Zero register.** With `ZERO_REG`=1, `wr r0` followed by a read of r0 gives `forwardA`=0 and no stall. With `ZERO_REG`=0 the same sequence forwards from stage 2.
- **Simultaneous events.** Assert `flush` and `stall` together: stage 1 takes a bubble and the counter increments. Assert `ext_stall` for 3 cycles during a load-use: the tracker is frozen, the counter does not change, and forwarding resumes unchanged afterwards.
- **Reset mid-operation.** Pull `rst_n` low with a load in stage 1: all outputs go to 0 asynchronously, and a dependent instruction issued after release does not stall.
- **Saturation and depth sweep.** With `CNT_W`=4, 20 stall cycles leave `stall_count`=15. With `DEPTH`=`LOAD_STAGE`=4, a load directly followed by a consumer gives `stall`=1 for 2 cycles and then `forwardA`=4.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the Lapido forwarding/hazard unit.
package hfu_pkg;

  localparam int unsigned FWD_RF     = 0;
  localparam int unsigned HFU_AW_MAX = 8;

  function automatic int unsigned sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // rd is stored zero-extended to HFU_AW_MAX so one record type fits every REG_AW.
  typedef struct packed {
    logic                  v;
    logic                  wr;
    logic                  ld;
    logic [HFU_AW_MAX-1:0] rd;
  } stage_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-side request and EX/PC-side response bundle of the forwarding/hazard unit.
interface hfu_if import hfu_pkg::*; #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned IW = sel_w(DEPTH);

  logic              id_valid;
  logic              id_regWrite;
  logic              id_memRead;
  logic [REG_AW-1:0] id_registerRD;
  logic [REG_AW-1:0] id_registerA;
  logic [REG_AW-1:0] id_registerB;
  logic              id_useA;
  logic              id_useB;
  logic              flush;
  logic              ext_stall;
  logic              stall;
  logic [IW-1:0]     forwardA;
  logic [IW-1:0]     forwardB;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_regWrite, id_memRead, id_registerRD, id_registerA, id_registerB,
    output id_useA, id_useB, flush, ext_stall,
    input  stall, forwardA, forwardB, stall_count
  );

  modport slave (
    input  id_valid, id_regWrite, id_memRead, id_registerRD, id_registerA, id_registerB,
    input  id_useA, id_useB, flush, ext_stall,
    output stall, forwardA, forwardB, stall_count
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_match.sv
// Priority matcher: lowest stage in START..STOP whose live writer targets the source.
module fwd_match import hfu_pkg::*; #(
  parameter  int unsigned DEPTH    = 3,
  parameter  int unsigned START    = 1,
  parameter  int unsigned STOP     = 2,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned IW       = sel_w(DEPTH)
) (
  input  logic [DEPTH:1]                 i_v,
  input  logic [DEPTH:1]                 i_wr,
  input  logic [DEPTH:1][HFU_AW_MAX-1:0] i_rd,
  input  logic [HFU_AW_MAX-1:0]          i_src,
  input  logic                           i_use,
  output logic [IW-1:0]                  o_idx,
  output logic                           o_found
);

  logic w_src_ok;

  assign w_src_ok = i_use && !(ZERO_REG && (i_src == '0));

  // Scan oldest to youngest so the youngest hit is the one left standing.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int s = int'(DEPTH); s >= 1; s--) begin
      if ((s >= int'(START)) && (s <= int'(STOP)) && w_src_ok &&
          i_v[s] && i_wr[s] && (i_rd[s] == i_src)) begin
        o_idx   = IW'(s);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Writer tracker producing EX forward selects, ID load-use stall and a stall counter.
module hazard_forward_unit import hfu_pkg::*; #(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 3,
  parameter bit          ZERO_REG   = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input logic  clk,
  input logic  rst_n,
  hfu_if.slave io_bus
);

  localparam int unsigned IW = sel_w(DEPTH);

  stage_t [DEPTH:1]        r_stg;
  logic [HFU_AW_MAX-1:0]   r_src_a;
  logic [HFU_AW_MAX-1:0]   r_src_b;
  logic                    r_use_a;
  logic                    r_use_b;
  logic [CNT_W-1:0]        r_cnt;

  logic [DEPTH:1]                 w_v;
  logic [DEPTH:1]                 w_wr;
  logic [DEPTH:1][HFU_AW_MAX-1:0] w_rd;
  logic [DEPTH:0]                 w_ld;
  logic [REG_AW-1:0]              w_id_rd_raw;
  logic [REG_AW-1:0]              w_id_a_raw;
  logic [REG_AW-1:0]              w_id_b_raw;
  logic [HFU_AW_MAX-1:0]          w_id_rd;
  logic [HFU_AW_MAX-1:0]          w_id_a;
  logic [HFU_AW_MAX-1:0]          w_id_b;
  logic [IW-1:0]                  w_fa_idx;
  logic [IW-1:0]                  w_fb_idx;
  logic [IW-1:0]                  w_sa_idx;
  logic [IW-1:0]                  w_sb_idx;
  logic                           w_fa_found;
  logic                           w_fb_found;
  logic                           w_sa_found;
  logic                           w_sb_found;
  logic                           w_haz_a;
  logic                           w_haz_b;
  logic                           w_stall;
  logic                           w_take;
  stage_t                         w_id_stg;

  assign w_id_rd_raw = io_bus.id_registerRD;
  assign w_id_a_raw  = io_bus.id_registerA;
  assign w_id_b_raw  = io_bus.id_registerB;
  assign w_id_rd     = HFU_AW_MAX'(w_id_rd_raw);
  assign w_id_a      = HFU_AW_MAX'(w_id_a_raw);
  assign w_id_b      = HFU_AW_MAX'(w_id_b_raw);

  always_comb begin
    w_v  = '0;
    w_wr = '0;
    w_rd = '0;
    w_ld = '0;
    for (int s = 1; s <= int'(DEPTH); s++) begin
      w_v[s]  = r_stg[s].v;
      w_wr[s] = r_stg[s].wr;
      w_rd[s] = r_stg[s].rd;
      w_ld[s] = r_stg[s].ld;
    end
  end

  fwd_match #(.DEPTH(DEPTH), .START(2), .STOP(DEPTH), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .i_v(w_v), .i_wr(w_wr), .i_rd(w_rd), .i_src(r_src_a), .i_use(r_use_a),
    .o_idx(w_fa_idx), .o_found(w_fa_found)
  );

  fwd_match #(.DEPTH(DEPTH), .START(2), .STOP(DEPTH), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .i_v(w_v), .i_wr(w_wr), .i_rd(w_rd), .i_src(r_src_b), .i_use(r_use_b),
    .o_idx(w_fb_idx), .o_found(w_fb_found)
  );

  fwd_match #(.DEPTH(DEPTH), .START(1), .STOP(DEPTH - 1), .ZERO_REG(ZERO_REG)) u_stall_a (
    .i_v(w_v), .i_wr(w_wr), .i_rd(w_rd), .i_src(w_id_a), .i_use(io_bus.id_useA),
    .o_idx(w_sa_idx), .o_found(w_sa_found)
  );

  fwd_match #(.DEPTH(DEPTH), .START(1), .STOP(DEPTH - 1), .ZERO_REG(ZERO_REG)) u_stall_b (
    .i_v(w_v), .i_wr(w_wr), .i_rd(w_rd), .i_src(w_id_b), .i_use(io_bus.id_useB),
    .o_idx(w_sb_idx), .o_found(w_sb_found)
  );

  // Only the youngest producer counts, so an ALU writer in front masks an older load.
  assign w_haz_a = w_sa_found && w_ld[w_sa_idx] && ((32'(w_sa_idx) + 32'd1) < LOAD_STAGE);
  assign w_haz_b = w_sb_found && w_ld[w_sb_idx] && ((32'(w_sb_idx) + 32'd1) < LOAD_STAGE);
  assign w_stall = io_bus.id_valid && (w_haz_a || w_haz_b);
  assign w_take  = io_bus.id_valid && !w_stall && !io_bus.flush;

  always_comb begin
    w_id_stg    = '0;
    w_id_stg.v  = 1'b1;
    w_id_stg.wr = io_bus.id_regWrite;
    w_id_stg.ld = io_bus.id_memRead;
    w_id_stg.rd = w_id_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg   <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_use_a <= 1'b0;
      r_use_b <= 1'b0;
      r_cnt   <= '0;
    end else if (!io_bus.ext_stall) begin
      for (int s = int'(DEPTH); s >= 2; s--) begin
        r_stg[s] <= r_stg[s-1];
      end
      r_stg[1] <= w_take ? w_id_stg : '0;
      if (w_take) begin
        r_src_a <= w_id_a;
        r_src_b <= w_id_b;
        r_use_a <= io_bus.id_useA;
        r_use_b <= io_bus.id_useB;
      end
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign io_bus.stall       = w_stall;
  assign io_bus.forwardA    = w_fa_found ? w_fa_idx : IW'(FWD_RF);
  assign io_bus.forwardB    = w_fb_found ? w_fb_idx : IW'(FWD_RF);
  assign io_bus.stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed checks of hazard_forward_unit at defaults and at DEPTH=LOAD_STAGE=4, CNT_W=4.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hfu_if #(.REG_AW(4), .DEPTH(3), .CNT_W(16)) bus0 ();
  hfu_if #(.REG_AW(4), .DEPTH(4), .CNT_W(4))  bus1 ();

  hazard_forward_unit #(
    .REG_AW(4), .DEPTH(3), .LOAD_STAGE(3), .ZERO_REG(1'b1), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus0)
  );

  hazard_forward_unit #(
    .REG_AW(4), .DEPTH(4), .LOAD_STAGE(4), .ZERO_REG(1'b0), .CNT_W(4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id0(input logic v, input logic wr, input logic ld, input int rd,
                     input int a, input int b, input logic ua, input logic ub);
    bus0.id_valid      = v;
    bus0.id_regWrite   = wr;
    bus0.id_memRead    = ld;
    bus0.id_registerRD = 4'(rd);
    bus0.id_registerA  = 4'(a);
    bus0.id_registerB  = 4'(b);
    bus0.id_useA       = ua;
    bus0.id_useB       = ub;
  endtask

  task automatic id1(input logic v, input logic wr, input logic ld, input int rd,
                     input int a, input int b, input logic ua, input logic ub);
    bus1.id_valid      = v;
    bus1.id_regWrite   = wr;
    bus1.id_memRead    = ld;
    bus1.id_registerRD = 4'(rd);
    bus1.id_registerA  = 4'(a);
    bus1.id_registerB  = 4'(b);
    bus1.id_useA       = ua;
    bus1.id_useB       = ub;
  endtask

  task automatic drain();
    id0(0, 0, 0, 0, 0, 0, 0, 0);
    id1(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus0.flush = 1'b0;
    bus0.ext_stall = 1'b0;
    bus1.flush = 1'b0;
    bus1.ext_stall = 1'b0;
    id0(0, 0, 0, 0, 0, 0, 0, 0);
    id1(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_stall", bus0.stall, 0);
    check("rst_fwdA", bus0.forwardA, 0);
    check("rst_fwdB", bus0.forwardB, 0);
    check("rst_cnt", bus0.stall_count, 0);
    #9 rst_n = 1'b1;
    tick();

    // add r3 ; sub r5,r3,r3
    id0(1, 1, 0, 3, 1, 2, 1, 1); #1 check("alu_add_stall", bus0.stall, 0); tick();
    id0(1, 1, 0, 5, 3, 3, 1, 1); #1 check("alu_sub_stall", bus0.stall, 0); tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1
    check("alu_fwdA", bus0.forwardA, 2);
    check("alu_fwdB", bus0.forwardB, 2);
    drain();

    // Two writers of r3, then reader: youngest wins.
    id0(1, 1, 0, 3, 1, 2, 1, 1); tick();
    id0(1, 1, 0, 3, 1, 2, 1, 1); tick();
    id0(1, 1, 0, 6, 3, 7, 1, 0); tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1
    check("youngest_fwdA", bus0.forwardA, 2);
    check("unused_fwdB", bus0.forwardB, 0);
    drain();

    // ld r4 ; add r1,r4,r2
    id0(1, 1, 1, 4, 0, 0, 0, 0); tick();
    id0(1, 1, 0, 1, 4, 2, 1, 1); #1 check("lu_stall_c1", bus0.stall, 1); tick();
    #1 check("lu_stall_c2", bus0.stall, 0); tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1
    check("lu_fwdA", bus0.forwardA, 3);
    check("lu_fwdB", bus0.forwardB, 0);
    check("lu_cnt", bus0.stall_count, 1);
    drain();

    // r0 writer then r0 reader on both configurations.
    id0(1, 1, 1, 0, 1, 2, 0, 0);
    id1(1, 1, 0, 0, 1, 2, 1, 1);
    tick();
    id0(1, 1, 0, 5, 0, 0, 1, 1);
    id1(1, 1, 0, 5, 0, 0, 1, 1);
    #1
    check("zr1_stall", bus0.stall, 0);
    check("zr0_stall", bus1.stall, 0);
    tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0);
    id1(0, 0, 0, 0, 0, 0, 0, 0);
    #1
    check("zr1_fwdA", bus0.forwardA, 0);
    check("zr1_fwdB", bus0.forwardB, 0);
    check("zr0_fwdA", bus1.forwardA, 2);
    check("zr0_fwdB", bus1.forwardB, 2);
    drain();

    // flush together with a load-use stall
    id0(1, 1, 1, 4, 0, 0, 0, 0); tick();
    id0(1, 1, 0, 1, 4, 2, 1, 1); bus0.flush = 1'b1;
    #1 check("fs_stall", bus0.stall, 1); tick();
    bus0.flush = 1'b0;
    id0(1, 1, 0, 9, 1, 0, 1, 0);
    #1
    check("fs_reader_stall", bus0.stall, 0);
    check("fs_cnt", bus0.stall_count, 2);
    tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1 check("fs_bubble_fwdA", bus0.forwardA, 0);
    drain();

    // plain flush kills a writer
    id0(1, 1, 0, 7, 1, 2, 1, 1); bus0.flush = 1'b1; tick();
    bus0.flush = 1'b0;
    id0(1, 1, 0, 8, 7, 7, 1, 1); tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1 check("flush_fwdA", bus0.forwardA, 0);
    drain();

    // ext_stall held 3 cycles during a load-use
    id0(1, 1, 1, 4, 0, 0, 0, 0); tick();
    id0(1, 1, 0, 1, 4, 2, 1, 1); bus0.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("es_stall_frozen", bus0.stall, 1); tick();
    end
    check("es_cnt_frozen", bus0.stall_count, 2);
    bus0.ext_stall = 1'b0;
    #1 check("es_stall_resume", bus0.stall, 1); tick();
    #1
    check("es_stall_clear", bus0.stall, 0);
    check("es_cnt", bus0.stall_count, 3);
    tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1
    check("es_fwdA", bus0.forwardA, 3);
    check("es_fwdB", bus0.forwardB, 0);
    drain();

    // reset with a load in stage 1 and a live forward
    id0(1, 1, 0, 3, 1, 2, 1, 1); tick();
    id0(1, 1, 1, 4, 3, 0, 1, 0); tick();
    id0(1, 1, 0, 1, 4, 2, 1, 1); #1
    check("pre_rst_fwdA", bus0.forwardA, 2);
    check("pre_rst_stall", bus0.stall, 1);
    check("pre_rst_cnt", bus0.stall_count, 3);
    rst_n = 1'b0;
    #1
    check("mid_rst_fwdA", bus0.forwardA, 0);
    check("mid_rst_stall", bus0.stall, 0);
    check("mid_rst_cnt", bus0.stall_count, 0);
    #1 rst_n = 1'b1;
    #1 check("post_rst_stall", bus0.stall, 0);
    tick();
    id0(0, 0, 0, 0, 0, 0, 0, 0); #1 check("post_rst_fwdA", bus0.forwardA, 0);
    drain();

    // DEPTH=LOAD_STAGE=4: two stall cycles, then forward from stage 4
    id1(1, 1, 1, 4, 0, 0, 0, 0); tick();
    id1(1, 1, 0, 1, 4, 2, 1, 1); #1 check("d4_stall_c1", bus1.stall, 1); tick();
    #1 check("d4_stall_c2", bus1.stall, 1); tick();
    #1 check("d4_stall_c3", bus1.stall, 0); tick();
    id1(0, 0, 0, 0, 0, 0, 0, 0); #1
    check("d4_fwdA", bus1.forwardA, 4);
    check("d4_cnt", bus1.stall_count, 2);
    drain();

    // nine more pairs: 20 stall cycles in total saturate a 4-bit counter
    for (int p = 0; p < 9; p++) begin
      id1(1, 1, 1, 4, 0, 0, 0, 0); tick();
      id1(1, 1, 0, 1, 4, 2, 1, 1); repeat (3) tick();
    end
    drain();
    check("sat_cnt", bus1.stall_count, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
